// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding and defaults for the hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HDU_RUN       = 2'd0,
    HDU_TRAP_PEND = 2'd1,
    HDU_REFILL    = 2'd2
  } hdu_state_e;

  localparam int HDU_XLEN      = 32;
  localparam int HDU_PERF_W    = 32;
  localparam int HDU_FETCH_LAT = 2;
  localparam int HDU_CNT_W     = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard inputs and stall/flush/redirect controls
interface hazard_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic            load_dependence;
  logic            ifu_not_ready;
  logic            ex_br_take;
  logic [XLEN-1:0] ex_br_target;
  logic            mem_lsu_busy;
  logic            mem_trap_req;
  logic [XLEN-1:0] mem_trap_vector;
  logic            mem_mret_req;
  logic [XLEN-1:0] mem_mepc;

  logic              if_stall;
  logic              id_stall;
  logic              ex_stall;
  logic              mem_stall;
  logic              id_flush;
  logic              ex_flush;
  logic              mem_flush;
  logic              pc_redirect;
  logic [XLEN-1:0]   pc_redirect_target;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output load_dependence, ifu_not_ready, ex_br_take, ex_br_target, mem_lsu_busy,
           mem_trap_req, mem_trap_vector, mem_mret_req, mem_mepc,
    input  if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, mem_flush,
           pc_redirect, pc_redirect_target, stall_cycles
  );

  modport slave (
    input  load_dependence, ifu_not_ready, ex_br_take, ex_br_target, mem_lsu_busy,
           mem_trap_req, mem_trap_vector, mem_mret_req, mem_mepc,
    output if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, mem_flush,
           pc_redirect, pc_redirect_target, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - per-stage stall/flush and PC redirect sequencing for the 5-stage core
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN      = HDU_XLEN,
  parameter int FETCH_LAT = HDU_FETCH_LAT,
  parameter int PERF_W    = HDU_PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [HDU_CNT_W-1:0] REFILL_LOAD = HDU_CNT_W'(FETCH_LAT - 1);

  hdu_state_e           state_q, state_d;
  logic [HDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      pend_q, pend_d;
  logic [PERF_W-1:0]    stall_cnt_q;

  logic            if_stall, id_stall, ex_stall, mem_stall;
  logic            id_flush, ex_flush, mem_flush;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            trap_any;
  logic [XLEN-1:0] trap_tgt;
  logic            refill_tick;

  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    mem_stall   = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_flush   = 1'b0;
    redirect    = 1'b0;
    target      = '0;
    refill_tick = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    trap_any    = hz.mem_trap_req | hz.mem_mret_req;
    trap_tgt    = hz.mem_trap_req ? hz.mem_trap_vector : hz.mem_mepc;

    if (!rst) begin
      case (state_q)
        HDU_TRAP_PEND: begin
          // Further trap/mret pulses are ignored until the held one is delivered.
          if (hz.mem_lsu_busy) begin
            {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
          end else begin
            redirect                        = 1'b1;
            target                          = pend_q;
            {id_flush, ex_flush, mem_flush} = 3'b111;
            state_d                         = HDU_REFILL;
            cnt_d                           = REFILL_LOAD;
          end
        end
        default: begin
          if (trap_any && hz.mem_lsu_busy) begin
            {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
            pend_d  = trap_tgt;
            state_d = HDU_TRAP_PEND;
          end else if (trap_any) begin
            redirect                        = 1'b1;
            target                          = trap_tgt;
            {id_flush, ex_flush, mem_flush} = 3'b111;
            state_d                         = HDU_REFILL;
            cnt_d                           = REFILL_LOAD;
          end else if (hz.mem_lsu_busy) begin
            // EX is frozen, so a taken branch there is held and acted on once MEM drains.
            {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
            refill_tick = 1'b1;
          end else if (hz.ex_br_take) begin
            redirect             = 1'b1;
            target               = hz.ex_br_target;
            {id_flush, ex_flush} = 2'b11;
            state_d              = HDU_REFILL;
            cnt_d                = REFILL_LOAD;
          end else if (state_q == HDU_RUN) begin
            if (hz.load_dependence) begin
              if_stall = 1'b1;
              id_stall = 1'b1;
              ex_flush = 1'b1;
            end else if (hz.ifu_not_ready) begin
              id_flush = 1'b1;
            end
          end else begin
            refill_tick = 1'b1;
          end

          // Wrong-path fetches land in ID during refill; the flush overrides any ID stall.
          if (state_q == HDU_REFILL) begin
            id_flush = 1'b1;
            id_stall = 1'b0;
            if (refill_tick) begin
              if (cnt_q == '0) state_d = HDU_RUN;
              else             cnt_d   = cnt_q - 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDU_RUN;
      cnt_q       <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (if_stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign hz.if_stall           = if_stall;
  assign hz.id_stall           = id_stall;
  assign hz.ex_stall           = ex_stall;
  assign hz.mem_stall          = mem_stall;
  assign hz.id_flush           = id_flush;
  assign hz.ex_flush           = ex_flush;
  assign hz.mem_flush          = mem_flush;
  assign hz.pc_redirect        = redirect;
  assign hz.pc_redirect_target = target;
  assign hz.stall_cycles       = stall_cnt_q;

endmodule
